// File: rtl/can_pkg.sv
// Shared types and constants for the CAN frame-tail sequencer.
package can_pkg;

    typedef enum logic [2:0] {
        P_NONE,
        P_EOF,
        P_INTER,
        P_IDLE,
        P_FLAG,
        P_WAIT_REC,
        P_DELIM,
        P_INTEG
    } phase_t;

    typedef enum logic {
        K_ERROR    = 1'b0,
        K_OVERLOAD = 1'b1
    } kind_t;

    localparam int EOF_BITS   = 7;
    localparam int INTER_BITS = 3;
    localparam int FLAG_BITS  = 6;
    localparam int DELIM_BITS = 8;
    localparam int IDLE_BITS  = 11;

endpackage

// File: rtl/can_frame_tail_sequencer_if.sv
// Protocol-FSM <-> frame-tail sequencer signal bundle.
interface can_frame_tail_sequencer_if;

    logic reset_mode_i;
    logic sample_point_i;
    logic sampled_bit_i;
    logic integrating_i;
    logic is_eof_i;
    logic is_inter_i;
    logic is_idle_i;
    logic is_error_frame_i;
    logic is_overload_frame_i;
    logic go_rx_inter_o;
    logic go_rx_idle_o;
    logic go_rx_id1_o;
    logic go_error_frame_o;
    logic go_overload_frame_o;
    logic overload_frame_ended_o;
    logic bus_free_o;
    logic tx_dominant_o;

    modport master (
        output reset_mode_i, sample_point_i, sampled_bit_i,
        output integrating_i, is_eof_i, is_inter_i, is_idle_i,
        output is_error_frame_i, is_overload_frame_i,
        input  go_rx_inter_o, go_rx_idle_o, go_rx_id1_o,
        input  go_error_frame_o, go_overload_frame_o,
        input  overload_frame_ended_o, bus_free_o, tx_dominant_o
    );

    modport slave (
        input  reset_mode_i, sample_point_i, sampled_bit_i,
        input  integrating_i, is_eof_i, is_inter_i, is_idle_i,
        input  is_error_frame_i, is_overload_frame_i,
        output go_rx_inter_o, go_rx_idle_o, go_rx_id1_o,
        output go_error_frame_o, go_overload_frame_o,
        output overload_frame_ended_o, bus_free_o, tx_dominant_o
    );

endinterface

// File: rtl/can_bit_counter.sv
// Saturating bit counter with clear, enable and terminal-count compare.
module can_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc_hit
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != {CNT_W{1'b1}})
            cnt <= cnt + 1'b1;
    end

    assign tc_hit = (cnt == tc);

endmodule

// File: rtl/can_frame_tail_sequencer.sv
// Bit sequencer for EOF, intermission, error/overload frames and bus integration.
module can_frame_tail_sequencer
    import can_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input logic clk_i,
    input logic rst_i,
    can_frame_tail_sequencer_if.slave m
);

    localparam int B_INTER = 6;
    localparam int B_IDLE  = 5;
    localparam int B_ID1   = 4;
    localparam int B_ERR   = 3;
    localparam int B_OVL   = 2;
    localparam int B_OEND  = 1;
    localparam int B_FREE  = 0;

    localparam logic [CNT_W-1:0] TC_EOF   = CNT_W'(EOF_BITS - 1);
    localparam logic [CNT_W-1:0] TC_INTER = CNT_W'(INTER_BITS - 1);
    localparam logic [CNT_W-1:0] TC_FLAG  = CNT_W'(FLAG_BITS - 1);
    localparam logic [CNT_W-1:0] TC_DELIM = CNT_W'(DELIM_BITS - 1);
    localparam logic [CNT_W-1:0] TC_INTEG = CNT_W'(IDLE_BITS - 1);

    phase_t           phase_q, phase_d;
    kind_t            kind_q, kind_d;
    logic             tx_q, tx_d;
    logic [6:0]       pulse_q, pulse_d;
    logic [5:0]       flags, flags_q, rise;
    logic             cnt_clr, cnt_en, tc_hit, bit_v;
    logic [CNT_W-1:0] cnt, tc;

    assign flags = {m.is_error_frame_i, m.is_overload_frame_i, m.is_eof_i,
                    m.is_inter_i, m.is_idle_i, m.integrating_i};
    assign rise  = flags & ~flags_q;
    assign bit_v = m.sampled_bit_i;

    can_bit_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .tc     (tc),
        .cnt    (cnt),
        .tc_hit (tc_hit)
    );

    always_comb begin
        tc = '0;
        unique case (phase_q)
            P_EOF:   tc = TC_EOF;
            P_INTER: tc = TC_INTER;
            P_FLAG:  tc = TC_FLAG;
            P_DELIM: tc = TC_DELIM;
            P_INTEG: tc = TC_INTEG;
            default: tc = '0;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        kind_d  = kind_q;
        tx_d    = tx_q;
        pulse_d = '0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (m.reset_mode_i) begin
            phase_d = P_NONE;
            cnt_clr = 1'b1;
            tx_d    = 1'b0;
        end else if (|rise) begin
            // entry beats a coincident strobe; error/overload beat the rest
            cnt_clr = 1'b1;
            tx_d    = rise[5] | rise[4];
            if (rise[5]) begin
                phase_d = P_FLAG;
                kind_d  = K_ERROR;
            end else if (rise[4]) begin
                phase_d = P_FLAG;
                kind_d  = K_OVERLOAD;
            end else if (rise[3]) begin
                phase_d = P_EOF;
            end else if (rise[2]) begin
                phase_d = P_INTER;
            end else if (rise[1]) begin
                phase_d = P_IDLE;
            end else begin
                phase_d = P_INTEG;
            end
        end else if (m.sample_point_i) begin
            unique case (phase_q)
                P_EOF: begin
                    if (!bit_v) begin
                        pulse_d[tc_hit ? B_OVL : B_ERR] = 1'b1;
                        phase_d = P_NONE;
                    end else if (tc_hit) begin
                        pulse_d[B_INTER] = 1'b1;
                        phase_d = P_NONE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                P_INTER: begin
                    if (!bit_v) begin
                        pulse_d[tc_hit ? B_ID1 : B_OVL] = 1'b1;
                        phase_d = P_NONE;
                    end else if (tc_hit) begin
                        pulse_d[B_IDLE] = 1'b1;
                        phase_d = P_NONE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                P_IDLE: begin
                    if (!bit_v) begin
                        pulse_d[B_ID1] = 1'b1;
                        phase_d = P_NONE;
                    end
                end
                P_FLAG: begin
                    if (tc_hit) begin
                        tx_d    = 1'b0;
                        cnt_clr = 1'b1;
                        phase_d = P_WAIT_REC;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                P_WAIT_REC: begin
                    // first recessive bit is delimiter bit 1
                    if (bit_v) begin
                        cnt_en  = 1'b1;
                        phase_d = P_DELIM;
                    end
                end
                P_DELIM: begin
                    if (!bit_v) begin
                        pulse_d[B_ERR] = 1'b1;
                        phase_d = P_FLAG;
                        kind_d  = K_ERROR;
                        tx_d    = 1'b1;
                        cnt_clr = 1'b1;
                    end else if (tc_hit) begin
                        pulse_d[B_INTER] = 1'b1;
                        pulse_d[B_OEND]  = (kind_q == K_OVERLOAD);
                        phase_d = P_NONE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                P_INTEG: begin
                    if (!bit_v) begin
                        cnt_clr = 1'b1;
                    end else if (tc_hit) begin
                        pulse_d[B_FREE] = 1'b1;
                        phase_d = P_NONE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= P_NONE;
            kind_q  <= K_ERROR;
            tx_q    <= 1'b0;
            pulse_q <= '0;
            flags_q <= '0;
        end else begin
            phase_q <= phase_d;
            kind_q  <= kind_d;
            tx_q    <= tx_d;
            pulse_q <= pulse_d;
            flags_q <= flags;
        end
    end

    assign m.go_rx_inter_o          = pulse_q[B_INTER];
    assign m.go_rx_idle_o           = pulse_q[B_IDLE];
    assign m.go_rx_id1_o            = pulse_q[B_ID1];
    assign m.go_error_frame_o       = pulse_q[B_ERR];
    assign m.go_overload_frame_o    = pulse_q[B_OVL];
    assign m.overload_frame_ended_o = pulse_q[B_OEND];
    assign m.bus_free_o             = pulse_q[B_FREE];
    assign m.tx_dominant_o          = tx_q;

endmodule

// File: tb/tb_can_frame_tail_sequencer.sv
// Scoreboard bench for can_frame_tail_sequencer with a scenario-level model.
module tb_can_frame_tail_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    can_frame_tail_sequencer_if bus();

    can_frame_tail_sequencer #(.CNT_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .m     (bus)
    );

    typedef struct {
        int         cyc;
        logic [6:0] p;
    } exp_t;

    localparam logic [6:0] E_NONE  = 7'b0000000;
    localparam logic [6:0] E_INTER = 7'b1000000;
    localparam logic [6:0] E_IDLE  = 7'b0100000;
    localparam logic [6:0] E_ID1   = 7'b0010000;
    localparam logic [6:0] E_ERR   = 7'b0001000;
    localparam logic [6:0] E_OVL   = 7'b0000100;
    localparam logic [6:0] E_OEND  = 7'b0000010;
    localparam logic [6:0] E_FREE  = 7'b0000001;

    localparam int F_ERR = 5, F_OVL = 4, F_EOF = 3;
    localparam int F_INTER = 2, F_IDLE = 1, F_INTEG = 0;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [6:0] pulses;

    assign pulses = {bus.go_rx_inter_o, bus.go_rx_idle_o, bus.go_rx_id1_o,
                     bus.go_error_frame_o, bus.go_overload_frame_o,
                     bus.overload_frame_ended_o, bus.bus_free_o};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_pulse: got none, expected %b at cycle %0d",
                         sb[0].p, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (pulses != 7'b0) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: got %b at cycle %0d, expected none",
                             pulses, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.p !== pulses || mon_e.cyc != cyc) begin
                        failures++;
                        $display("FAIL pulse: got %b at cycle %0d, expected %b at cycle %0d",
                                 pulses, cyc, mon_e.p, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_flags(input logic [5:0] f);
        bus.is_error_frame_i    = f[5];
        bus.is_overload_frame_i = f[4];
        bus.is_eof_i            = f[3];
        bus.is_inter_i          = f[2];
        bus.is_idle_i           = f[1];
        bus.integrating_i       = f[0];
    endtask

    task automatic enter(input int f);
        logic [5:0] v;
        v = '0;
        v[f] = 1'b1;
        @(posedge clk); #1;
        set_flags(6'b0);
        @(posedge clk); #1;
        set_flags(v);
    endtask

    // One bus bit at a sample point, with its expected response
    task automatic send_bit(input logic b, input logic [6:0] e, input logic tx_exp);
        repeat ($urandom_range(3, 5)) @(posedge clk);
        #1;
        check("tx_dominant", int'(bus.tx_dominant_o), int'(tx_exp));
        bus.sampled_bit_i  = b;
        bus.sample_point_i = 1'b1;
        if (e != E_NONE) sb.push_back('{cyc + 1, e});
        @(posedge clk); #1;
        bus.sample_point_i = 1'b0;
        bus.sampled_bit_i  = 1'b1;
    endtask

    task automatic run_eof(input logic [6:0] bits);
        enter(F_EOF);
        for (int i = 0; i < 7; i++) begin
            if (!bits[i]) begin
                send_bit(1'b0, (i < 6) ? E_ERR : E_OVL, 1'b0);
                return;
            end
            send_bit(1'b1, (i == 6) ? E_INTER : E_NONE, 1'b0);
        end
    endtask

    task automatic run_inter(input logic [2:0] bits);
        enter(F_INTER);
        for (int i = 0; i < 3; i++) begin
            if (!bits[i]) begin
                send_bit(1'b0, (i < 2) ? E_OVL : E_ID1, 1'b0);
                return;
            end
            send_bit(1'b1, (i == 2) ? E_IDLE : E_NONE, 1'b0);
        end
    endtask

    task automatic run_idle(input int n_rec);
        enter(F_IDLE);
        for (int i = 0; i < n_rec; i++) send_bit(1'b1, E_NONE, 1'b0);
        send_bit(1'b0, E_ID1, 1'b0);
    endtask

    // dom_pos: 0 = clean delimiter, else delimiter bit (2..8) driven dominant
    task automatic run_frame(input logic ovl, input int wait_n, input int dom_pos);
        logic k;
        int   dp;
        int   wn;
        k  = ovl;
        dp = dom_pos;
        wn = wait_n;
        enter(ovl ? F_OVL : F_ERR);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 6; i++)
                send_bit(1'($urandom_range(0, 1)), E_NONE, 1'b1);
            for (int i = 0; i < wn; i++) send_bit(1'b0, E_NONE, 1'b0);
            for (int d = 1; d <= 8; d++) begin
                if (d == dp) begin
                    send_bit(1'b0, E_ERR, 1'b0);
                    break;
                end
                send_bit(1'b1, (d == 8) ? (k ? (E_INTER | E_OEND) : E_INTER) : E_NONE,
                         1'b0);
            end
            if (dp == 0) break;
            k  = 1'b0;
            dp = 0;
            wn = $urandom_range(0, 2);
        end
    endtask

    task automatic run_integ(input logic directed);
        int  run;
        logic b;
        run = 0;
        enter(F_INTEG);
        for (int n = 0; n < 80; n++) begin
            if (directed) b = (n != 10);
            else b = (n > 40) ? 1'b1 : ($urandom_range(0, 5) != 0);
            run = b ? run + 1 : 0;
            send_bit(b, (run == 11) ? E_FREE : E_NONE, 1'b0);
            if (run == 11) break;
        end
    endtask

    task automatic run_reset_mode();
        enter(F_ERR);
        send_bit(1'b0, E_NONE, 1'b1);
        send_bit(1'b1, E_NONE, 1'b1);
        @(posedge clk); #1;
        bus.reset_mode_i = 1'b1;
        @(posedge clk); #1;
        check("tx_after_reset_mode", int'(bus.tx_dominant_o), 0);
        send_bit(1'b0, E_NONE, 1'b0);
        bus.reset_mode_i = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(1'b0, E_NONE, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] v7;
        logic [2:0] v3;
        bus.reset_mode_i   = 1'b0;
        bus.sample_point_i = 1'b0;
        bus.sampled_bit_i  = 1'b1;
        set_flags(6'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_pulses", int'(pulses), 0);
        check("reset_tx", int'(bus.tx_dominant_o), 0);
        rst = 1'b0;

        run_eof(7'b1111111);
        run_eof(7'b1110111);
        run_eof(7'b0111111);
        run_inter(3'b011);
        run_inter(3'b101);
        run_inter(3'b111);
        run_frame(1'b0, 3, 0);
        run_frame(1'b0, 0, 5);
        run_frame(1'b1, 0, 0);
        run_integ(1'b1);
        run_reset_mode();
        run_idle(3);

        repeat (40) begin
            case ($urandom_range(0, 5))
                0: begin
                    for (int i = 0; i < 7; i++) v7[i] = ($urandom_range(0, 9) != 0);
                    run_eof(v7);
                end
                1: begin
                    for (int i = 0; i < 3; i++) v3[i] = ($urandom_range(0, 3) != 0);
                    run_inter(v3);
                end
                2: run_idle($urandom_range(0, 5));
                3: run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 3),
                             ($urandom_range(0, 2) == 0) ? $urandom_range(2, 8) : 0);
                4: run_integ(1'b0);
                default: run_reset_mode();
            endcase
        end

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
